// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared widths, FSM/kind encodings and cause codes for the cpu6 trap sequencer.
package cpu6_trap_ctrl_pkg;

  localparam int CPU6_XLEN     = 32;
  localparam int CPU6_CSR_SIZE = 12;
  localparam int CPU6_CAUSE_W  = 4;

  localparam logic [31:0] CPU6_MTVEC_TRAP_BASE = 32'h0000_0100;

  localparam logic [3:0] CPU6_CAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] CPU6_CAUSE_INSTR_FAULT    = 4'd1;
  localparam logic [3:0] CPU6_CAUSE_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] CPU6_CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CPU6_CAUSE_ECALL_M        = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SAVE  = 2'd2,
    ST_REDIR = 2'd3
  } trap_state_e;

  // Reset value of kind is EXC, so a cleared register decodes as EXC.
  typedef enum logic {
    KIND_EXC = 1'b0,
    KIND_RET = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/cpu6_trap_ctrl.sv
// Trap sequencer: arbitrates the CSR port between pipeline CSR instructions and
// exception entry / mret return sequences (flush, save, redirect).
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN     = CPU6_XLEN,
  parameter int CSR_SIZE = CPU6_CSR_SIZE,
  parameter int CAUSE_W  = CPU6_CAUSE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                excp_req,
  input  logic [CAUSE_W-1:0]  excp_cause,
  input  logic [XLEN-1:0]     excp_pc,
  input  logic                mret_req,
  input  logic                csr_instr_req,
  input  logic                csr_instr_wr,
  input  logic [CSR_SIZE-1:0] csr_instr_idx,
  input  logic [XLEN-1:0]     csr_instr_wdat,
  output logic                csr_instr_gnt,
  output logic                csr_rd_en,
  output logic                csr_wr_en,
  output logic [CSR_SIZE-1:0] csr_idx,
  output logic [XLEN-1:0]     csr_write_dat,
  output logic [XLEN-1:0]     excp_mepc,
  output logic                excp_mepc_ena,
  output logic [CAUSE_W-1:0]  excp_mcause,
  output logic                excp_mcause_ena,
  input  logic [XLEN-1:0]     csr_mtvec,
  input  logic [XLEN-1:0]     csr_mepc,
  output logic                flush,
  output logic                redirect_vld,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                busy
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  trap_state_e        state_q, state_d;
  trap_kind_e         kind_q, kind_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_EXC;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  // Requests are only looked at in IDLE; exception beats mret beats CSR access.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (excp_req) begin
          pc_d    = excp_pc & ALIGN_MASK;
          cause_d = excp_cause;
          kind_d  = KIND_EXC;
          state_d = ST_FLUSH;
        end else if (mret_req) begin
          kind_d  = KIND_RET;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = (kind_q == KIND_EXC) ? ST_SAVE : ST_REDIR;
      ST_SAVE:  state_d = ST_REDIR;
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // CSR handshake: csr_instr_req is a level request held by the pipeline;
  // csr_instr_gnt in the same cycle means the access happened this cycle,
  // otherwise the request must be held or re-issued.
  always_comb begin
    csr_instr_gnt   = 1'b0;
    csr_rd_en       = 1'b0;
    csr_wr_en       = 1'b0;
    csr_idx         = '0;
    csr_write_dat   = '0;
    excp_mepc       = '0;
    excp_mepc_ena   = 1'b0;
    excp_mcause     = '0;
    excp_mcause_ena = 1'b0;
    flush           = 1'b0;
    redirect_vld    = 1'b0;
    redirect_pc     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!reset && !excp_req && !mret_req && csr_instr_req) begin
          csr_instr_gnt = 1'b1;
          csr_rd_en     = !csr_instr_wr;
          csr_wr_en     = csr_instr_wr;
          csr_idx       = csr_instr_idx;
          csr_write_dat = csr_instr_wdat;
        end
      end
      ST_FLUSH: flush = 1'b1;
      ST_SAVE: begin
        excp_mepc       = pc_q;
        excp_mepc_ena   = 1'b1;
        excp_mcause     = cause_q;
        excp_mcause_ena = 1'b1;
      end
      ST_REDIR: begin
        redirect_vld = 1'b1;
        redirect_pc  = ((kind_q == KIND_EXC) ? csr_mtvec : csr_mepc) & ALIGN_MASK;
      end
      default: ;
    endcase
    busy = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Self-checking bench for cpu6_trap_ctrl: CSR pass-through table, directed
// trap/return/reset sequences, and random traffic against a phase-queue model.
module tb_cpu6_trap_ctrl;
  import cpu6_trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        excp_req;
  logic [3:0]  excp_cause;
  logic [31:0] excp_pc;
  logic        mret_req;
  logic        csr_instr_req;
  logic        csr_instr_wr;
  logic [11:0] csr_instr_idx;
  logic [31:0] csr_instr_wdat;
  logic        csr_instr_gnt;
  logic        csr_rd_en;
  logic        csr_wr_en;
  logic [11:0] csr_idx;
  logic [31:0] csr_write_dat;
  logic [31:0] excp_mepc;
  logic        excp_mepc_ena;
  logic [3:0]  excp_mcause;
  logic        excp_mcause_ena;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        flush;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  cpu6_trap_ctrl dut (
    .clk(clk), .reset(reset),
    .excp_req(excp_req), .excp_cause(excp_cause), .excp_pc(excp_pc),
    .mret_req(mret_req),
    .csr_instr_req(csr_instr_req), .csr_instr_wr(csr_instr_wr),
    .csr_instr_idx(csr_instr_idx), .csr_instr_wdat(csr_instr_wdat),
    .csr_instr_gnt(csr_instr_gnt), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en),
    .csr_idx(csr_idx), .csr_write_dat(csr_write_dat),
    .excp_mepc(excp_mepc), .excp_mepc_ena(excp_mepc_ena),
    .excp_mcause(excp_mcause), .excp_mcause_ena(excp_mcause_ena),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .flush(flush), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  logic [119:0] obs;
  assign obs = {csr_instr_gnt, csr_rd_en, csr_wr_en, csr_idx, csr_write_dat,
                excp_mepc, excp_mepc_ena, excp_mcause, excp_mcause_ena,
                flush, redirect_vld, redirect_pc, busy};

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [119:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    excp_req = 0; excp_cause = 0; excp_pc = 0; mret_req = 0;
    csr_instr_req = 0; csr_instr_wr = 0; csr_instr_idx = 0; csr_instr_wdat = 0;
  endtask

  // scoreboard: queue of expected sequencer phases still to be observed
  localparam logic [1:0] PH_FLUSH = 2'd1, PH_SAVE = 2'd2, PH_REDIR = 2'd3;
  logic [1:0]  exp_q[$];
  logic [31:0] m_pc;
  logic [3:0]  m_cause;
  logic        m_exc;

  task automatic model_check(input string name);
    logic gnt, rd, wr, me, mc, fl, rv, bz;
    logic [11:0] ix;
    logic [31:0] wd, mp, rp;
    logic [3:0]  ca;
    logic [1:0]  ph;
    gnt = 0; rd = 0; wr = 0; me = 0; mc = 0; fl = 0; rv = 0; bz = 0;
    ix = 0; wd = 0; mp = 0; rp = 0; ca = 0;
    if (exp_q.size() > 0) begin
      ph = exp_q.pop_front();
      bz = 1;
      if (ph == PH_FLUSH) fl = 1;
      if (ph == PH_SAVE) begin me = 1; mc = 1; mp = m_pc; ca = m_cause; end
      if (ph == PH_REDIR) begin
        rv = 1;
        rp = (m_exc ? csr_mtvec : csr_mepc) & 32'hFFFF_FFFE;
      end
    end else if (excp_req) begin
      m_pc = excp_pc & 32'hFFFF_FFFE;
      m_cause = excp_cause;
      m_exc = 1;
      exp_q.push_back(PH_FLUSH); exp_q.push_back(PH_SAVE); exp_q.push_back(PH_REDIR);
    end else if (mret_req) begin
      m_exc = 0;
      exp_q.push_back(PH_FLUSH); exp_q.push_back(PH_REDIR);
    end else if (csr_instr_req) begin
      gnt = 1; rd = !csr_instr_wr; wr = csr_instr_wr;
      ix = csr_instr_idx; wd = csr_instr_wdat;
    end
    check_vec(name, {gnt, rd, wr, ix, wd, mp, me, ca, mc, fl, rv, rp, bz});
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [11:0] idx;
    logic [31:0] wdat;
    logic        e_gnt;
    logic        e_rd;
    logic        e_wr;
    logic [11:0] e_idx;
    logic [31:0] e_wdat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    clear_inputs();
    csr_mtvec = 0; csr_mepc = 0;
    reset = 1;

    vecs[0] = '{1, 1, 12'h341, 32'h0000_0055, 1, 0, 1, 12'h341, 32'h0000_0055};
    vecs[1] = '{1, 0, 12'h300, 32'h0000_1111, 1, 1, 0, 12'h300, 32'h0000_1111};
    vecs[2] = '{0, 1, 12'h342, 32'hDEAD_BEEF, 0, 0, 0, 12'h000, 32'h0000_0000};
    vecs[3] = '{1, 1, 12'hFFF, 32'hFFFF_FFFF, 1, 0, 1, 12'hFFF, 32'hFFFF_FFFF};
    vecs[4] = '{1, 0, 12'h000, 32'h0000_0000, 1, 1, 0, 12'h000, 32'h0000_0000};
    vecs[5] = '{1, 1, 12'h305, 32'h8000_0001, 1, 0, 1, 12'h305, 32'h8000_0001};

    // reset state, including a CSR request held during reset
    next_cycle();
    check_vec("reset_outputs", '0);
    csr_instr_req = 1; csr_instr_wr = 1; csr_instr_idx = 12'h341;
    #1 check_val("reset_no_gnt", {31'd0, csr_instr_gnt}, 32'd0);
    clear_inputs();
    next_cycle();
    reset = 0;
    next_cycle();

    // CSR pass-through table
    for (int i = 0; i < 6; i++) begin
      csr_instr_req = vecs[i].req; csr_instr_wr = vecs[i].wr;
      csr_instr_idx = vecs[i].idx; csr_instr_wdat = vecs[i].wdat;
      #1;
      check_vec($sformatf("csr_vec%0d", i),
        {vecs[i].e_gnt, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_idx, vecs[i].e_wdat,
         32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0});
      next_cycle();
    end
    clear_inputs();

    // exception entry with simultaneous mret and CSR write (priority)
    csr_mtvec = 32'h0000_0100;
    excp_req = 1; excp_pc = 32'h0000_1235; excp_cause = CPU6_CAUSE_ILLEGAL_INSTR;
    mret_req = 1; csr_instr_req = 1; csr_instr_wr = 1; csr_instr_idx = 12'h341;
    #1 check_val("prio_gnt_wr", {30'd0, csr_instr_gnt, csr_wr_en}, 32'd0);
    next_cycle();
    clear_inputs();
    check_val("exc_t1_flush_busy", {29'd0, flush, busy, redirect_vld}, 32'd6);
    next_cycle();
    check_val("exc_t2_mepc", excp_mepc, 32'h0000_1234);
    check_val("exc_t2_cause_strobes", {26'd0, excp_mcause, excp_mepc_ena, excp_mcause_ena}, 32'h0000_000B);
    check_val("exc_t2_flush_low", {31'd0, flush}, 32'd0);
    next_cycle();
    check_val("exc_t3_redir", {31'd0, redirect_vld}, 32'd1);
    check_val("exc_t3_pc", redirect_pc, 32'h0000_0100);
    check_val("exc_t3_ena_low", {31'd0, excp_mepc_ena}, 32'd0);
    next_cycle();
    check_val("exc_t4_idle", {30'd0, busy, redirect_vld}, 32'd0);

    // mret return, with a CSR read held throughout
    csr_mepc = 32'h0000_2000;
    mret_req = 1; csr_instr_req = 1; csr_instr_wr = 0; csr_instr_idx = 12'h300;
    #1 check_val("ret_t0_gnt", {31'd0, csr_instr_gnt}, 32'd0);
    next_cycle();
    mret_req = 0;
    check_val("ret_t1", {27'd0, flush, csr_instr_gnt, csr_rd_en, excp_mepc_ena, busy}, 32'h11);
    next_cycle();
    check_val("ret_t2_redir", {28'd0, redirect_vld, excp_mepc_ena, excp_mcause_ena, csr_instr_gnt}, 32'h8);
    check_val("ret_t2_pc", redirect_pc, 32'h0000_2000);
    next_cycle();
    check_val("ret_t3_gnt_idle", {29'd0, csr_instr_gnt, csr_rd_en, busy}, 32'h6);
    clear_inputs();
    next_cycle();

    // reset asserted while in SAVE
    csr_mtvec = 32'h0000_0200;
    excp_req = 1; excp_pc = 32'h0000_4000; excp_cause = CPU6_CAUSE_ECALL_M;
    next_cycle();
    clear_inputs();
    next_cycle();
    check_val("rst_pre_save", {31'd0, excp_mepc_ena}, 32'd1);
    reset = 1;
    #1 check_vec("rst_mid_save", '0);
    next_cycle();
    reset = 0;
    check_vec("rst_after_idle", '0);
    csr_mepc = 32'h0000_3001;
    mret_req = 1;
    next_cycle();
    mret_req = 0;
    check_val("rst_ret_flush", {31'd0, flush}, 32'd1);
    next_cycle();
    check_val("rst_ret_redir", {31'd0, redirect_vld}, 32'd1);
    check_val("rst_ret_pc", redirect_pc, 32'h0000_3000);
    next_cycle();
    check_val("rst_ret_idle", {31'd0, busy}, 32'd0);

    // random traffic against the phase-queue model
    exp_q.delete();
    m_pc = 0; m_cause = 0; m_exc = 0;
    for (int c = 0; c < 600; c++) begin
      excp_req       = ($urandom_range(0, 9) == 0);
      mret_req       = ($urandom_range(0, 9) == 0);
      csr_instr_req  = ($urandom_range(0, 1) == 1);
      csr_instr_wr   = $urandom_range(0, 1);
      csr_instr_idx  = 12'($urandom_range(0, 4095));
      csr_instr_wdat = $urandom();
      excp_pc        = $urandom();
      excp_cause     = 4'($urandom_range(0, 15));
      csr_mtvec      = $urandom();
      csr_mepc       = $urandom();
      #1 model_check($sformatf("rand_c%0d", c));
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
